// File: rtl/span_filler.sv
// span_filler
// Rasterizer back end: buffers horizontal fill spans in a small FIFO and
// writes every covered, on-screen pixel through a single-pixel write master
// that honours fb_waitrequest.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears FIFO, FSM and outputs
//   span_valid     span offered (xa, xb, y, colour)
//   span_ready     FIFO has a free slot
//   span_xa/xb     span endpoints, any order, 0..511
//   span_y         span row, 0..511
//   span_color     fill colour
//   fb_address     pixel address, y*FB_WIDTH + x
//   fb_writedata   pixel colour
//   fb_write       write request, held until accepted
//   fb_waitrequest slave stall; write accepted when fb_write && !fb_waitrequest
//   idle           FIFO empty and FSM idle (registered)
//
// FSM states
//   state    | meaning
//   ST_IDLE  | waiting; pops the FIFO head into the working registers
//   ST_LOAD  | clips the working span, discards it or presents its first pixel
//   ST_WRITE | fb_write high; advances one pixel per accepted write

module span_filler #(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int COLOR_W    = 16,
    parameter int ADDR_W     = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               span_valid,
    output logic               span_ready,
    input  logic [8:0]         span_xa,
    input  logic [8:0]         span_xb,
    input  logic [8:0]         span_y,
    input  logic [COLOR_W-1:0] span_color,
    output logic [ADDR_W-1:0]  fb_address,
    output logic [COLOR_W-1:0] fb_writedata,
    output logic               fb_write,
    input  logic               fb_waitrequest,
    output logic               idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = 27 + COLOR_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [8:0]       X_LIM    = 9'(FB_WIDTH);
    localparam logic [8:0]       X_MAX    = 9'(FB_WIDTH - 1);
    localparam logic [8:0]       Y_LIM    = 9'(FB_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Span FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign span_ready = (count != CNT_FULL);
    assign push       = span_valid && span_ready;
    assign head       = mem[rd_ptr];
    assign count_n    = count + CNT_W'(push) - CNT_W'(pop);

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {span_xa, span_xb, span_y, span_color};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_n;
        end
    end

    // ------------------------------------------------------------------
    // Working span registers, loaded on pop
    // ------------------------------------------------------------------
    logic [8:0]         w_xa;
    logic [8:0]         w_xb;
    logic [8:0]         w_y;
    logic [COLOR_W-1:0] w_color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_xa    <= '0;
            w_xb    <= '0;
            w_y     <= '0;
            w_color <= '0;
        end else if (pop) begin
            {w_xa, w_xb, w_y, w_color} <= head;
        end
    end

    // Clipping of the working span: left edge is the smaller endpoint,
    // right edge the larger one limited to the last visible column.
    logic [8:0]        xl;
    logic [8:0]        xh;
    logic [8:0]        xr_clip;
    logic              discard;
    logic [ADDR_W-1:0] load_addr;

    assign xl        = (w_xa < w_xb) ? w_xa : w_xb;
    assign xh        = (w_xa < w_xb) ? w_xb : w_xa;
    assign xr_clip   = (xh > X_MAX) ? X_MAX : xh;
    assign discard   = (w_y >= Y_LIM) || (xl >= X_LIM);
    assign load_addr = ADDR_W'(w_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(xl);

    // ------------------------------------------------------------------
    // Pixel FSM
    // ------------------------------------------------------------------
    state_t             state;
    state_t             state_n;
    logic [8:0]         x;
    logic [8:0]         x_n;
    logic [8:0]         xr;
    logic [8:0]         xr_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [COLOR_W-1:0] data_n;
    logic               write_n;
    logic               idle_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            x            <= '0;
            xr           <= '0;
            fb_address   <= '0;
            fb_writedata <= '0;
            fb_write     <= 1'b0;
            idle         <= 1'b1;
        end else begin
            state        <= state_n;
            x            <= x_n;
            xr           <= xr_n;
            fb_address   <= addr_n;
            fb_writedata <= data_n;
            fb_write     <= write_n;
            idle         <= idle_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        xr_n    = xr;
        addr_n  = fb_address;
        data_n  = fb_writedata;
        write_n = fb_write;
        pop     = 1'b0;

        case (state)
            ST_IDLE: begin
                write_n = 1'b0;
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (discard) begin
                    state_n = ST_IDLE;
                end else begin
                    x_n     = xl;
                    xr_n    = xr_clip;
                    addr_n  = load_addr;
                    data_n  = w_color;
                    write_n = 1'b1;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!fb_waitrequest) begin
                    if (x == xr) begin
                        write_n = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        x_n    = x + 9'd1;
                        addr_n = fb_address + ADDR_W'(1);
                    end
                end
            end
            default: begin
                write_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        // idle reflects the state/count the registers are about to hold,
        // so the flop output matches the current FSM state and FIFO level.
        idle_n = (state_n == ST_IDLE) && (count_n == '0);
    end

endmodule

// File: tb/tb_span_filler.sv
module tb_span_filler;

    logic        clk = 1'b0;
    logic        reset;
    logic        span_valid;
    logic        span_ready;
    logic [8:0]  span_xa;
    logic [8:0]  span_xb;
    logic [8:0]  span_y;
    logic [15:0] span_color;
    logic [16:0] fb_address;
    logic [15:0] fb_writedata;
    logic        fb_write;
    logic        fb_waitrequest;
    logic        idle;

    span_filler dut (
        .clk           (clk),
        .reset         (reset),
        .span_valid    (span_valid),
        .span_ready    (span_ready),
        .span_xa       (span_xa),
        .span_xb       (span_xb),
        .span_y        (span_y),
        .span_color    (span_color),
        .fb_address    (fb_address),
        .fb_writedata  (fb_writedata),
        .fb_write      (fb_write),
        .fb_waitrequest(fb_waitrequest),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_cycles = 0;
    bit rand_stall = 0;

    logic [16:0] obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_cyc[$];
    logic [16:0] exp_addr[$];
    logic [15:0] exp_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes mid-cycle; an accepted write is one presented with
    // waitrequest low, which takes effect at the following rising edge.
    always @(negedge clk) begin
        if (!reset && fb_write) begin
            wr_cycles++;
            if (!fb_waitrequest) begin
                obs_addr.push_back(fb_address);
                obs_data.push_back(fb_writedata);
                obs_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_stall) fb_waitrequest = ($urandom_range(0, 2) == 0);
        end
    end

    // Reference: every on-screen pixel of the span, left to right.
    task automatic model_span(input int xa, input int xb, input int y, input int c);
        int lo, hi;
        lo = (xa < xb) ? xa : xb;
        hi = (xa < xb) ? xb : xa;
        if (hi > 319) hi = 319;
        if (y < 240 && lo < 320) begin
            for (int x = lo; x <= hi; x++) begin
                exp_addr.push_back(17'(y * 320 + x));
                exp_data.push_back(16'(c));
            end
        end
    endtask

    task automatic clear_queues();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
        wr_cycles = 0;
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input int xa, input int xb, input int y, input int c, output bit ok);
        span_valid = 1'b1;
        span_xa    = 9'(xa);
        span_xb    = 9'(xb);
        span_y     = 9'(y);
        span_color = 16'(c);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (span_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
        span_valid = 1'b0;
        if (ok) model_span(xa, xb, y, c);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (idle) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        span_valid = 1'b0;
        span_xa = '0; span_xb = '0; span_y = '0; span_color = '0;
        fb_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (span_ready !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", span_ready); else n_pass++;
        n_checks++;
        if (fb_write !== 1'b0) $display("FAIL reset_write: got %b, expected 0", fb_write); else n_pass++;
        n_checks++;
        if (fb_address !== 17'd0) $display("FAIL reset_addr: got %0d, expected 0", fb_address); else n_pass++;
        n_checks++;
        if (fb_writedata !== 16'h0) $display("FAIL reset_data: got %h, expected 0000", fb_writedata); else n_pass++;
        n_checks++;
        if (idle !== 1'b1) $display("FAIL reset_idle: got %b, expected 1", idle); else n_pass++;
    endtask

    // Basic span, timing of first write, then reversed span back to back.
    task automatic test_basic();
        bit ok, ok2, okw;
        clear_queues();
        send(10, 13, 2, 16'hF800, ok);
        @(posedge clk);
        #1;
        n_checks++;
        if (fb_write !== 1'b0) $display("FAIL basic_load_write: got %b, expected 0", fb_write); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (fb_write !== 1'b1 || fb_address !== 17'd650)
            $display("FAIL basic_first_write: got write %b addr %0d, expected write 1 addr 650", fb_write, fb_address);
        else n_pass++;
        send(13, 10, 2, 16'h07E0, ok2);
        wait_idle(okw);
        n_checks++;
        if (!(ok && ok2 && okw)) $display("FAIL basic_timeout: send %b %b idle %b, expected all 1", ok, ok2, okw); else n_pass++;
        n_checks++;
        if (obs_addr.size() !== exp_addr.size())
            $display("FAIL basic_count: got %0d writes, expected %0d", obs_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL basic_pixel[%0d]: got addr %0d data %h, expected addr %0d data %h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
        n_checks++;
        if (wr_cycles !== 8) $display("FAIL basic_write_cycles: got %0d, expected 8", wr_cycles); else n_pass++;
        if (obs_cyc.size() >= 5) begin
            n_checks++;
            if (obs_cyc[4] - obs_cyc[3] !== 3)
                $display("FAIL basic_gap: got %0d cycles between spans, expected 3", obs_cyc[4] - obs_cyc[3]);
            else n_pass++;
        end
        n_checks++;
        if (idle !== 1'b1) $display("FAIL basic_idle: got %b, expected 1", idle); else n_pass++;
    endtask

    task automatic test_clip();
        bit ok, okall, okw;
        int tbl[6][3] = '{'{315, 400, 0}, '{5, 5, 240}, '{320, 320, 3},
                          '{0, 0, 7}, '{511, 300, 1}, '{511, 511, 0}};
        clear_queues();
        okall = 1;
        for (int i = 0; i < 6; i++) begin
            send(tbl[i][0], tbl[i][1], tbl[i][2], 16'h1000 + i, ok);
            okall &= ok;
        end
        wait_idle(okw);
        n_checks++;
        if (!(okall && okw)) $display("FAIL clip_timeout: send %b idle %b, expected 1 1", okall, okw); else n_pass++;
        n_checks++;
        if (obs_addr.size() !== exp_addr.size())
            $display("FAIL clip_count: got %0d writes, expected %0d", obs_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL clip_pixel[%0d]: got addr %0d data %h, expected addr %0d data %h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit ok, okw, seen;
        clear_queues();
        send(0, 3, 1, 16'hABCD, ok);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (fb_write && fb_address == 17'd321) seen = 1;
        end
        n_checks++;
        if (!seen) $display("FAIL stall_reach_321: got addr %0d, expected 321 presented", fb_address); else n_pass++;
        fb_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (fb_write !== 1'b1 || fb_address !== 17'd321 || fb_writedata !== 16'hABCD)
                $display("FAIL stall_hold[%0d]: got write %b addr %0d data %h, expected 1 321 abcd",
                         k, fb_write, fb_address, fb_writedata);
            else n_pass++;
        end
        fb_waitrequest = 1'b0;
        wait_idle(okw);
        n_checks++;
        if (!(ok && okw)) $display("FAIL stall_timeout: send %b idle %b, expected 1 1", ok, okw); else n_pass++;
        n_checks++;
        if (obs_addr.size() !== exp_addr.size())
            $display("FAIL stall_count: got %0d writes, expected %0d", obs_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL stall_pixel[%0d]: got addr %0d data %h, expected addr %0d data %h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok, okall, okw;
        int xa[6], xb[6], y[6];
        clear_queues();
        for (int i = 0; i < 6; i++) begin
            xa[i] = $urandom_range(0, 330);
            xb[i] = $urandom_range(0, 330);
            y[i]  = 10 + i;
        end
        fb_waitrequest = 1'b1;
        okall = 1;
        for (int i = 0; i < 5; i++) begin
            send(xa[i], xb[i], y[i], 16'h2000 + i, ok);
            okall &= ok;
        end
        n_checks++;
        if (span_ready !== 1'b0) $display("FAIL bp_full_ready: got %b, expected 0", span_ready); else n_pass++;
        span_valid = 1'b1;
        span_xa = 9'(xa[5]); span_xb = 9'(xb[5]); span_y = 9'(y[5]); span_color = 16'h2005;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (span_ready !== 1'b0) $display("FAIL bp_still_full: got %b, expected 0", span_ready); else n_pass++;
        fb_waitrequest = 1'b0;
        send(xa[5], xb[5], y[5], 16'h2005, ok);
        okall &= ok;
        wait_idle(okw);
        n_checks++;
        if (!(okall && okw)) $display("FAIL bp_timeout: send %b idle %b, expected 1 1", okall, okw); else n_pass++;
        n_checks++;
        if (obs_addr.size() !== exp_addr.size())
            $display("FAIL bp_count: got %0d writes, expected %0d", obs_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL bp_pixel[%0d]: got addr %0d data %h, expected addr %0d data %h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit ok, okall, okw;
        int xa, xb;
        clear_queues();
        rand_stall = 1;
        okall = 1;
        for (int i = 0; i < 25; i++) begin
            xa = $urandom_range(0, 511);
            xb = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 511)
                                             : ((xa + $urandom_range(0, 8)) % 512);
            send(xa, xb, $urandom_range(0, 250), $urandom_range(0, 65535), ok);
            okall &= ok;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(okw);
        rand_stall = 0;
        @(posedge clk);
        #2;
        fb_waitrequest = 1'b0;
        n_checks++;
        if (!(okall && okw)) $display("FAIL rand_timeout: send %b idle %b, expected 1 1", okall, okw); else n_pass++;
        n_checks++;
        if (obs_addr.size() !== exp_addr.size())
            $display("FAIL rand_count: got %0d writes, expected %0d", obs_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL rand_pixel[%0d]: got addr %0d data %h, expected addr %0d data %h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok, okall, okw, seen;
        clear_queues();
        okall = 1;
        send(0, 9, 5, 16'h3333, ok);   okall &= ok;
        send(20, 25, 6, 16'h4444, ok); okall &= ok;
        send(30, 35, 7, 16'h5555, ok); okall &= ok;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (fb_write && fb_address == 17'd1602) seen = 1;
        end
        n_checks++;
        if (!(okall && seen)) $display("FAIL rstmid_setup: send %b pixel2 %b, expected 1 1", okall, seen); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (fb_write !== 1'b0 || span_ready !== 1'b1 || idle !== 1'b1)
            $display("FAIL rstmid_async: got write %b ready %b idle %b, expected 0 1 1", fb_write, span_ready, idle);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_queues();
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (obs_addr.size() !== 0 || idle !== 1'b1)
            $display("FAIL rstmid_no_writes: got %0d writes idle %b, expected 0 writes idle 1", obs_addr.size(), idle);
        else n_pass++;
        send(100, 102, 9, 16'h6666, ok);
        wait_idle(okw);
        n_checks++;
        if (!(ok && okw)) $display("FAIL rstmid_timeout: send %b idle %b, expected 1 1", ok, okw); else n_pass++;
        n_checks++;
        if (obs_addr.size() !== exp_addr.size())
            $display("FAIL rstmid_count: got %0d writes, expected %0d", obs_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL rstmid_pixel[%0d]: got addr %0d data %h, expected addr %0d data %h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_stall();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
